// File: rtl/lc3_bus_gate_reg.sv
// Registered LC-3 bus gate: lowest-index gated source onto a held bus, with collision flagging.
// Optional saturating collision counter enabled by defining BUS_GATE_COLL_CNT_EN.
module lc3_bus_gate_reg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N*WIDTH-1:0]     data_in,
  input  logic [N-1:0]           gate,
  input  logic                   hold,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic [$clog2(N)-1:0]   src_idx,
  output logic                   collision,
  output logic                   err_sticky,
  output logic [CNT_W-1:0]       coll_cnt
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [WIDTH-1:0] sel_word;
  logic [IDX_W-1:0] sel_idx;
  logic             any_gate;
  logic             multi;
  logic             found;

  // Priority scan: the first (lowest) set gate bit wins on a collision.
  always_comb begin
    sel_word = '0;
    sel_idx  = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gate[i] && !found) begin
        found    = 1'b1;
        sel_word = data_in[i*WIDTH +: WIDTH];
        sel_idx  = IDX_W'(i);
      end
    end
  end

  assign any_gate = |gate;
  assign multi    = |(gate & (gate - N'(1)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus_out    <= '0;
      src_idx    <= '0;
      bus_valid  <= 1'b0;
      collision  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (!hold) begin
        bus_valid <= any_gate;
        if (any_gate) begin
          bus_out <= sel_word;
          src_idx <= sel_idx;
        end
      end
      collision <= multi;
      if (multi)
        err_sticky <= 1'b1;
      else if (clr_err)
        err_sticky <= 1'b0;
    end
  end

`ifdef BUS_GATE_COLL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset)
      cnt_q <= '0;
    else if (multi)
      cnt_q <= clr_err ? CNT_W'(1) : ((cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1));
    else if (clr_err)
      cnt_q <= '0;
  end

  assign coll_cnt = cnt_q;
`else
  assign coll_cnt = '0;
`endif

endmodule

// File: doc/lc3_bus_gate_reg.md
# lc3_bus_gate_reg

Parametrised, registered successor to the LC-3 datapath bus gate multiplexer. It selects one of N source words onto the shared datapath bus using a one-hot gate vector, then registers the result. It also detects gate collisions (more than one gate asserted at once) and holds the last bus value when no source is gated. It sits between the GatePC/GateMDR/GateALU/GateMARMUX-style gate signals and every bus consumer in the datapath.

## Interface
Parameters:
- WIDTH, 16, bit width of each source word and of the bus
- N, 4, number of sources (N ≥ 2)
- CNT_W, 8, width of the collision counter

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset; only one clock domain
- data_in  input  N*WIDTH  source words; source i occupies bits [i*WIDTH +: WIDTH]
- gate  input  N  gate vector, expected one-hot or all-zero
- hold  input  1  1 = freeze the bus register, the valid flag and the source index
- clr_err  input  1  clears err_sticky and coll_cnt
- bus_out  output  WIDTH  registered bus value
- bus_valid  output  1  bus_out was loaded from a gated source on the last update
- src_idx  output  $clog2(N)  index of the source that loaded bus_out
- collision  output  1  registered one-cycle pulse; gate was multi-hot in the previous cycle
- err_sticky  output  1  set by any collision, cleared only by clr_err or Reset
- coll_cnt  output  CNT_W  saturating collision count (see Configuration)

## Operation
Evaluation happens on every rising edge of Clk.
- **Reset = 1:** all outputs and internal registers go to 0. Reset overrides every other input.
- **hold = 0, gate all-zero:**
  - bus_out and src_idx keep their values.
  - bus_valid is set to 0.
- **hold = 0, gate one-hot with bit k set:**
  - bus_out is loaded with source k.
  - src_idx is set to k.
  - bus_valid is set to 1.
- **hold = 0, gate multi-hot:**
  - The lowest set index k wins; bus_out, src_idx and bus_valid load exactly as in the one-hot case.
  - The collision behaviour below also applies.
- **hold = 1:** bus_out, src_idx and bus_valid are all frozen. Collision detection still runs.
- **Collision detection (independent of hold):** when gate has two or more bits set:
  - collision is set to 1 for the next cycle; otherwise collision is 0.
  - err_sticky is set to 1.
- **clr_err = 1:** clears err_sticky to 0. If a collision occurs in the same cycle, the set wins and err_sticky ends at 1.

## Timing
- Latency is 1 cycle from gate/data_in to bus_out, bus_valid and src_idx. There is no combinational path from any input to any output.
- collision, err_sticky and coll_cnt all update on the same edge as the bus register.
- hold and clr_err are sampled on the same edge as gate.
- If Reset is asserted mid-stream, all outputs read 0 on the following cycle, regardless of gate, hold or clr_err.
- After Reset deasserts, the first gated cycle produces bus_valid = 1 one edge later.

## Configuration
The macro BUS_GATE_COLL_CNT_EN controls the collision counter.
- **Defined:**
  - coll_cnt increments by 1 on every cycle with a multi-hot gate.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - clr_err clears it to 0. If a collision occurs in the same cycle as clr_err, coll_cnt loads 1.
  - Reset clears it to 0.
- **Undefined:**
  - No counter flops are built.
  - The coll_cnt port still exists and is tied to constant 0.
  - All other behaviour is identical.

## Test plan
- **Reset then one-hot gate.** Stimulus: Reset for 2 cycles; then data_in sources 0..3 = 0x1111, 0x2222, 0x3333, 0x4444 and gate = 4'b0100. Required response: during Reset, all outputs are 0; one cycle after the gate, bus_out = 0x3333, src_idx = 2, bus_valid = 1, collision = 0.
- **Idle gate holds value.** Stimulus: after the previous scenario, gate = 4'b0000 for 3 cycles. Required response: bus_out stays 0x3333, src_idx stays 2, bus_valid = 0.
- **Collision.** Stimulus: gate = 4'b1010 for 1 cycle. Required response:
  - next cycle: bus_out = 0x2222, src_idx = 1, collision = 1, err_sticky = 1, coll_cnt = 1 (macro defined);
  - the cycle after: collision = 0 and err_sticky stays 1.
- **hold freezes the bus but not error detection.** Stimulus: hold = 1 with gate = 4'b0001, then gate = 4'b0011. Required response: bus_out stays 0x2222 throughout; collision pulses after the 4'b0011 cycle; coll_cnt reaches 2.
- **Clear versus set.**
  - Stimulus: clr_err = 1 with gate = 4'b0001. Required response: err_sticky = 0 and coll_cnt = 0.
  - Stimulus: clr_err = 1 with gate = 4'b1100. Required response: err_sticky = 1 and coll_cnt = 1.
- **Saturation.** Stimulus: CNT_W = 2, macro defined, 5 consecutive multi-hot cycles. Required response: coll_cnt sequence is 1, 2, 3, 3, 3. With the macro undefined, coll_cnt stays 0 throughout.
